// File: rtl/bin_display_scan.sv
// bin_display_scan: 14-bit binary to 4-digit BCD via double-dabble,
// time-multiplexed onto a 4-digit display with leading-zero blanking.
module bin_display_scan #(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        load_i,
  input  logic [13:0] value_i,
  output logic        busy_o,
  output logic        overflow_o,
  output logic [3:0]  bcd_o,
  output logic        blank_o,
  output logic [3:0]  digit_sel_o
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
  localparam logic [13:0] VMAX = 14'd9999;

  logic          busy_q, busy_d;
  logic          ovf_q, ovf_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [13:0]   sh_q, sh_d;
  logic [15:0]   work_q, work_d;
  logic [15:0]   disp_q, disp_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   adj;

  // add-3 correction of every work nibble that is 5 or more
  always_comb begin
    adj = work_q;
    for (int i = 0; i < 4; i++) begin
      if (work_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
    end
  end

  // accept a load or run one conversion step; display written once at the end
  always_comb begin
    busy_d = busy_q;
    ovf_d  = ovf_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    work_d = work_q;
    disp_d = disp_q;
    if (busy_q) begin
      {work_d, sh_d} = {adj, sh_q} << 1;
      cnt_d = cnt_q - 4'd1;
      if (cnt_q == 4'd1) begin
        busy_d = 1'b0;
        disp_d = work_d;
      end
    end else if (load_i) begin
      busy_d = 1'b1;
      cnt_d  = 4'd14;
      work_d = '0;
      if (value_i > VMAX) begin
        sh_d  = VMAX;
        ovf_d = 1'b1;
      end else begin
        sh_d  = value_i;
        ovf_d = 1'b0;
      end
    end
  end

  // free-running prescaler advancing the scan index on wrap
  always_comb begin
    pre_d = pre_q + PW'(1);
    idx_d = idx_q;
    if (pre_q == PMAX) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      sh_q   <= '0;
      work_q <= '0;
      disp_q <= '0;
      pre_q  <= '0;
      idx_q  <= '0;
    end else begin
      busy_q <= busy_d;
      ovf_q  <= ovf_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      work_q <= work_d;
      disp_q <= disp_d;
      pre_q  <= pre_d;
      idx_q  <= idx_d;
    end
  end

  // digit strobe, code and leading-zero blank for the selected digit
  always_comb begin
    digit_sel_o = 4'b0001 << idx_q;
    bcd_o       = disp_q[3:0];
    blank_o     = 1'b0;
    unique case (idx_q)
      2'd0: begin
        bcd_o   = disp_q[3:0];
        blank_o = 1'b0;
      end
      2'd1: begin
        bcd_o   = disp_q[7:4];
        blank_o = (disp_q[15:4] == 12'd0);
      end
      2'd2: begin
        bcd_o   = disp_q[11:8];
        blank_o = (disp_q[15:8] == 8'd0);
      end
      2'd3: begin
        bcd_o   = disp_q[15:12];
        blank_o = (disp_q[15:12] == 4'd0);
      end
    endcase
  end

  assign busy_o     = busy_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_bin_display_scan.sv
// tb_bin_display_scan: scoreboard bench with a decimal reference model
// of conversion timing, overflow clamping and the digit scan.
module tb_bin_display_scan;

  localparam int SD = 3;

  logic        clk;
  logic        reset;
  logic        load;
  logic [13:0] value;
  logic        busy;
  logic        overflow;
  logic [3:0]  bcd;
  logic        blank;
  logic [3:0]  digit_sel;

  bin_display_scan #(.SCAN_DIV(SD)) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .load_i      (load),
    .value_i     (value),
    .busy_o      (busy),
    .overflow_o  (overflow),
    .bcd_o       (bcd),
    .blank_o     (blank),
    .digit_sel_o (digit_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int m_left = 0;
  int m_ovf = 0;
  int m_disp = 0;
  int scan_t = 0;
  bit chk_en = 0;
  bit prev_busy = 0;
  int pow10[4] = '{1, 10, 100, 1000};

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // one clock: drive inputs, then advance the reference model at the edge
  task automatic step(input logic rst, input logic ld, input logic [13:0] v);
    reset = rst;
    load  = ld;
    value = v;
    @(posedge clk);
    if (rst) begin
      m_left = 0;
      m_ovf  = 0;
      m_disp = 0;
      scan_t = 0;
      exp_q.delete();
    end else begin
      scan_t++;
      if (m_left > 0) begin
        m_left--;
      end else if (ld) begin
        m_left = 14;
        m_ovf  = (v > 14'd9999) ? 1 : 0;
        exp_q.push_back((v > 14'd9999) ? 9999 : int'(v));
      end
    end
    chk_en = 1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 14'd0);
  endtask

  task automatic ld(input logic [13:0] v);
    step(1'b0, 1'b1, v);
  endtask

  // monitor: new digits appear when busy drops; check every cycle
  always @(negedge clk) begin
    int idx;
    int dg;
    if (chk_en) begin
      if (prev_busy && !busy && exp_q.size() > 0)
        m_disp = exp_q.pop_front();
      prev_busy = busy;
      idx = (scan_t / SD) % 4;
      dg  = (m_disp / pow10[idx]) % 10;
      chk("busy", int'(busy), (m_left != 0) ? 1 : 0);
      chk("overflow", int'(overflow), m_ovf);
      chk("digit_sel", int'(digit_sel), 1 << idx);
      chk("bcd", int'(bcd), dg);
      chk("blank", int'(blank), (idx > 0 && m_disp < pow10[idx]) ? 1 : 0);
    end
  end

  initial begin
    logic [13:0] v;
    int r;
    reset = 1'b1;
    load  = 1'b0;
    value = '0;
    step(1'b1, 1'b0, 14'd0);
    idle(14);
    ld(14'd1234);
    idle(30);
    ld(14'd7);
    idle(30);
    ld(14'd0);
    idle(30);
    ld(14'd1005);
    idle(30);
    ld(14'd12000);
    idle(30);
    ld(14'd42);
    idle(30);
    ld(14'd1234);
    idle(4);
    ld(14'd5678);
    idle(9);
    ld(14'd5678);
    idle(30);
    ld(14'd9999);
    idle(6);
    step(1'b1, 1'b0, 14'd0);
    idle(20);
    step(1'b1, 1'b1, 14'd4321);
    idle(20);
    ld(14'd16383);
    ld(14'd10000);
    idle(30);
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0: v = 14'($urandom_range(0, 16383));
        1: v = 14'($urandom_range(0, 9));
        2: v = 14'($urandom_range(0, 9999));
        default: v = 14'($urandom_range(9990, 10010));
      endcase
      step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, v);
    end
    idle(30);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
